// File: rtl/neuron_status_sequencer.sv
// neuron_status_sequencer
// Owns the status table {Vmem, gex, gin, RefVal} for 2^NEURON_ADDR_WIDTH
// neurons. On Start it walks every neuron once. For each neuron it spends two
// cycles: an ISSUE cycle that strobes the external neuron unit, then a CAPTURE
// cycle that stores the unit's updated status and reports any spike.
// Optional feature: define NEURON_SPIKE_COUNT_EN to add a per-sweep SpikeCount
// output. The default build leaves the macro undefined and has no counter.

module neuron_status_sequencer #(
  parameter int DATA_WIDTH        = 64,
  parameter int TREF_WIDTH        = 5,
  parameter int NEURON_ADDR_WIDTH = 4
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic                         InitWrEn,
  input  logic [NEURON_ADDR_WIDTH-1:0] InitAddr,
  input  logic signed [DATA_WIDTH-1:0] InitVmem,
  output logic                         UpdateEnable,
  output logic [NEURON_ADDR_WIDTH-1:0] NeuronAddr,
  output logic signed [DATA_WIDTH-1:0] Vmem,
  output logic signed [DATA_WIDTH-1:0] gex,
  output logic signed [DATA_WIDTH-1:0] gin,
  output logic [TREF_WIDTH+2:0]        RefVal,
  input  logic signed [DATA_WIDTH-1:0] VmemIn,
  input  logic signed [DATA_WIDTH-1:0] gexIn,
  input  logic signed [DATA_WIDTH-1:0] ginIn,
  input  logic [TREF_WIDTH+2:0]        RefValIn,
  input  logic                         SpikeIn,
  output logic                         SpikeValid,
  output logic [NEURON_ADDR_WIDTH-1:0] SpikeAddr,
  output logic                         Busy,
  output logic                         Done
`ifdef NEURON_SPIKE_COUNT_EN
  ,
  output logic [NEURON_ADDR_WIDTH:0]   SpikeCount
`endif
);

  localparam int NUM_NEURONS = 1 << NEURON_ADDR_WIDTH;
  localparam int REF_WIDTH   = TREF_WIDTH + 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t state;

  // Status table, one entry per neuron.
  logic signed [DATA_WIDTH-1:0] vmem_q   [NUM_NEURONS];
  logic signed [DATA_WIDTH-1:0] gex_q    [NUM_NEURONS];
  logic signed [DATA_WIDTH-1:0] gin_q    [NUM_NEURONS];
  logic        [REF_WIDTH-1:0]  refval_q [NUM_NEURONS];

  // Last reported spiking neuron, shown on SpikeAddr between spikes.
  logic [NEURON_ADDR_WIDTH-1:0] spike_addr_q;

  logic init_write;
  logic capture_write;

  // A load is only honoured while idle. A write-back happens on every
  // CAPTURE cycle.
  assign init_write    = (state == ST_IDLE) && InitWrEn;
  assign capture_write = (state == ST_CAPTURE);

  // The unit sees the entry under service directly, with no extra latency.
  assign Vmem   = vmem_q[NeuronAddr];
  assign gex    = gex_q[NeuronAddr];
  assign gin    = gin_q[NeuronAddr];
  assign RefVal = refval_q[NeuronAddr];

  // A spike is reported in the same cycle the unit flags it. The address
  // falls back to the last reported neuron when no spike is reported.
  assign SpikeValid = capture_write && SpikeIn;
  assign SpikeAddr  = SpikeValid ? NeuronAddr : spike_addr_q;

  // Sweep controller: steps through ISSUE/CAPTURE pairs per neuron and
  // drives the registered strobes.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= ST_IDLE;
      NeuronAddr   <= '0;
      UpdateEnable <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
    end else begin
      UpdateEnable <= 1'b0;
      Done         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state        <= ST_ISSUE;
            NeuronAddr   <= '0;
            UpdateEnable <= 1'b1;
            Busy         <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (NeuronAddr == NEURON_ADDR_WIDTH'(NUM_NEURONS - 1)) begin
            state      <= ST_DONE;
            NeuronAddr <= '0;
            Done       <= 1'b1;
          end else begin
            state        <= ST_ISSUE;
            NeuronAddr   <= NeuronAddr + 1'b1;
            UpdateEnable <= 1'b1;
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          NeuronAddr <= '0;
          Busy       <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          NeuronAddr <= '0;
          Busy       <= 1'b0;
        end
      endcase
    end
  end

  // Status table update. The table takes initial loads while idle and
  // unmodified write-backs from the unit during CAPTURE.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        vmem_q[i]   <= '0;
        gex_q[i]    <= '0;
        gin_q[i]    <= '0;
        refval_q[i] <= '0;
      end
    end else if (init_write) begin
      vmem_q[InitAddr]   <= InitVmem;
      gex_q[InitAddr]    <= '0;
      gin_q[InitAddr]    <= '0;
      refval_q[InitAddr] <= '0;
    end else if (capture_write) begin
      vmem_q[NeuronAddr]   <= VmemIn;
      gex_q[NeuronAddr]    <= gexIn;
      gin_q[NeuronAddr]    <= ginIn;
      refval_q[NeuronAddr] <= RefValIn;
    end
  end

  // Remember the most recent spiking neuron so SpikeAddr stays stable
  // between spikes.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      spike_addr_q <= '0;
    end else if (SpikeValid) begin
      spike_addr_q <= NeuronAddr;
    end
  end

`ifdef NEURON_SPIKE_COUNT_EN
  // Per-sweep spike tally. It clears when a sweep is accepted and holds its
  // value after Done until the next sweep starts.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      SpikeCount <= '0;
    end else if ((state == ST_IDLE) && Start) begin
      SpikeCount <= '0;
    end else if (SpikeValid) begin
      SpikeCount <= SpikeCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_neuron_status_sequencer.sv
// tb_neuron_status_sequencer
// Directed sequence of sweeps with randomized neuron-unit responses. A
// table-level reference model in the bench predicts every entry and strobe.
// Define NEURON_SPIKE_COUNT_EN for both files to also check SpikeCount.

module tb_neuron_status_sequencer;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int RW = 8;
  localparam int N  = 16;

  logic                 Clock;
  logic                 Reset;
  logic                 Start;
  logic                 InitWrEn;
  logic [AW-1:0]        InitAddr;
  logic signed [DW-1:0] InitVmem;
  logic                 UpdateEnable;
  logic [AW-1:0]        NeuronAddr;
  logic signed [DW-1:0] Vmem;
  logic signed [DW-1:0] gex;
  logic signed [DW-1:0] gin;
  logic [RW-1:0]        RefVal;
  logic signed [DW-1:0] VmemIn;
  logic signed [DW-1:0] gexIn;
  logic signed [DW-1:0] ginIn;
  logic [RW-1:0]        RefValIn;
  logic                 SpikeIn;
  logic                 SpikeValid;
  logic [AW-1:0]        SpikeAddr;
  logic                 Busy;
  logic                 Done;
`ifdef NEURON_SPIKE_COUNT_EN
  logic [AW:0]          SpikeCount;
`endif

  // Neuron-unit responses for the current sweep.
  logic signed [DW-1:0] resp_vmem   [N];
  logic signed [DW-1:0] resp_gex    [N];
  logic signed [DW-1:0] resp_gin    [N];
  logic [RW-1:0]        resp_refval [N];
  logic [N-1:0]         resp_spike;

  // Reference model: expected table contents and last spike address.
  logic [DW-1:0] ref_vmem   [N];
  logic [DW-1:0] ref_gex    [N];
  logic [DW-1:0] ref_gin    [N];
  logic [RW-1:0] ref_refval [N];
  int            last_spike;

  int checks;
  int failures;

  neuron_status_sequencer #(
    .DATA_WIDTH       (DW),
    .TREF_WIDTH       (5),
    .NEURON_ADDR_WIDTH(AW)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .InitWrEn    (InitWrEn),
    .InitAddr    (InitAddr),
    .InitVmem    (InitVmem),
    .UpdateEnable(UpdateEnable),
    .NeuronAddr  (NeuronAddr),
    .Vmem        (Vmem),
    .gex         (gex),
    .gin         (gin),
    .RefVal      (RefVal),
    .VmemIn      (VmemIn),
    .gexIn       (gexIn),
    .ginIn       (ginIn),
    .RefValIn    (RefValIn),
    .SpikeIn     (SpikeIn),
    .SpikeValid  (SpikeValid),
    .SpikeAddr   (SpikeAddr),
    .Busy        (Busy),
    .Done        (Done)
`ifdef NEURON_SPIKE_COUNT_EN
    ,
    .SpikeCount  (SpikeCount)
`endif
  );

  // Free-running clock.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // The unit answers for whichever neuron is addressed. SpikeIn is left
  // ungated so the sequencer's own qualification is exercised.
  assign VmemIn   = resp_vmem[NeuronAddr];
  assign gexIn    = resp_gex[NeuronAddr];
  assign ginIn    = resp_gin[NeuronAddr];
  assign RefValIn = resp_refval[NeuronAddr];
  assign SpikeIn  = resp_spike[NeuronAddr];

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < N; i++) begin
      ref_vmem[i]   = '0;
      ref_gex[i]    = '0;
      ref_gin[i]    = '0;
      ref_refval[i] = '0;
    end
    last_spike = 0;
  endtask

  task automatic setRespRandom(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      resp_vmem[i]   = {$urandom, $urandom};
      resp_gex[i]    = {$urandom, $urandom};
      resp_gin[i]    = {$urandom, $urandom};
      resp_refval[i] = RW'($urandom_range(0, 255));
    end
    resp_spike = mask;
  endtask

  task automatic setRespRamp(input logic [N-1:0] mask);
    setRespRandom(mask);
    for (int i = 0; i < N; i++) resp_vmem[i] = DW'(i + 1);
  endtask

  // Load one entry while idle; entered and left #1 after a rising edge.
  task automatic initWrite(input int addr, input logic [DW-1:0] val);
    InitWrEn = 1'b1;
    InitAddr = AW'(addr);
    InitVmem = val;
    @(posedge Clock); #1;
    InitWrEn = 1'b0;
    ref_vmem[addr]   = val;
    ref_gex[addr]    = '0;
    ref_gin[addr]    = '0;
    ref_refval[addr] = '0;
  endtask

  // Run one full sweep, numbering the Start cycle as cycle 0. An ISSUE for
  // neuron a falls in cycle 2a+1, its CAPTURE in 2a+2, and Done in 2N+1.
  // Optionally loads an entry alongside Start, and pulses Start and InitWrEn
  // mid-sweep; both of those late pulses must be ignored.
  task automatic applyStimulus(input string name, input bit with_init,
                               input int init_addr, input logic [DW-1:0] init_val,
                               input int restart_cycle, input int late_init_cycle);
    int a;
    int exp_count;
    Start = 1'b1;
    if (with_init) begin
      InitWrEn = 1'b1;
      InitAddr = AW'(init_addr);
      InitVmem = init_val;
      ref_vmem[init_addr]   = init_val;
      ref_gex[init_addr]    = '0;
      ref_gin[init_addr]    = '0;
      ref_refval[init_addr] = '0;
    end
    @(posedge Clock); #1;
    Start    = 1'b0;
    InitWrEn = 1'b0;
    for (int c = 1; c <= 2 * N + 4; c++) begin
      if (c <= 2 * N) begin
        a = (c - 1) / 2;
        checkOutput($sformatf("%s addr c%0d", name, c), DW'(NeuronAddr), DW'(a));
        checkOutput($sformatf("%s busy c%0d", name, c), DW'(Busy), 1);
        checkOutput($sformatf("%s done c%0d", name, c), DW'(Done), 0);
        if (c % 2 == 1) begin
          checkOutput($sformatf("%s ue c%0d", name, c), DW'(UpdateEnable), 1);
          checkOutput($sformatf("%s vmem a%0d", name, a), Vmem, ref_vmem[a]);
          checkOutput($sformatf("%s gex a%0d", name, a), gex, ref_gex[a]);
          checkOutput($sformatf("%s gin a%0d", name, a), gin, ref_gin[a]);
          checkOutput($sformatf("%s ref a%0d", name, a), DW'(RefVal), DW'(ref_refval[a]));
          checkOutput($sformatf("%s sv c%0d", name, c), DW'(SpikeValid), 0);
`ifdef NEURON_SPIKE_COUNT_EN
          exp_count = 0;
          for (int j = 0; j < a; j++) exp_count += int'(resp_spike[j]);
          checkOutput($sformatf("%s cnt c%0d", name, c), DW'(SpikeCount), DW'(exp_count));
`endif
        end else begin
          checkOutput($sformatf("%s ue c%0d", name, c), DW'(UpdateEnable), 0);
          checkOutput($sformatf("%s sv c%0d", name, c), DW'(SpikeValid), DW'(resp_spike[a]));
          if (resp_spike[a]) last_spike = a;
        end
        checkOutput($sformatf("%s saddr c%0d", name, c), DW'(SpikeAddr), DW'(last_spike));
      end else if (c == 2 * N + 1) begin
        checkOutput($sformatf("%s done c%0d", name, c), DW'(Done), 1);
        checkOutput($sformatf("%s busy c%0d", name, c), DW'(Busy), 1);
        checkOutput($sformatf("%s ue c%0d", name, c), DW'(UpdateEnable), 0);
        checkOutput($sformatf("%s sv c%0d", name, c), DW'(SpikeValid), 0);
      end else begin
        checkOutput($sformatf("%s done c%0d", name, c), DW'(Done), 0);
        checkOutput($sformatf("%s busy c%0d", name, c), DW'(Busy), 0);
        checkOutput($sformatf("%s ue c%0d", name, c), DW'(UpdateEnable), 0);
        checkOutput($sformatf("%s addr c%0d", name, c), DW'(NeuronAddr), 0);
        checkOutput($sformatf("%s sv c%0d", name, c), DW'(SpikeValid), 0);
`ifdef NEURON_SPIKE_COUNT_EN
        checkOutput($sformatf("%s cnt c%0d", name, c), DW'(SpikeCount), DW'($countones(resp_spike)));
`endif
      end
      if (c == restart_cycle) Start = 1'b1;
      if (c == late_init_cycle) begin
        InitWrEn = 1'b1;
        InitAddr = AW'(2);
        InitVmem = {$urandom, $urandom};
      end
      @(posedge Clock); #1;
      Start    = 1'b0;
      InitWrEn = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      ref_vmem[i]   = resp_vmem[i];
      ref_gex[i]    = resp_gex[i];
      ref_gin[i]    = resp_gin[i];
      ref_refval[i] = resp_refval[i];
    end
  endtask

  // Start a sweep, then assert Reset in the CAPTURE cycle of neuron 7.
  task automatic resetMidSweep();
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    for (int c = 1; c < 16; c++) begin
      @(posedge Clock); #1;
    end
    checkOutput("rst capture addr", DW'(NeuronAddr), 7);
    checkOutput("rst capture ue", DW'(UpdateEnable), 0);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    clearModel();
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("rst busy %0d", c), DW'(Busy), 0);
      checkOutput($sformatf("rst done %0d", c), DW'(Done), 0);
      checkOutput($sformatf("rst ue %0d", c), DW'(UpdateEnable), 0);
      checkOutput($sformatf("rst addr %0d", c), DW'(NeuronAddr), 0);
      checkOutput($sformatf("rst saddr %0d", c), DW'(SpikeAddr), 0);
      @(posedge Clock); #1;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset    = 1'b1;
    Start    = 1'b0;
    InitWrEn = 1'b0;
    InitAddr = '0;
    InitVmem = '0;
    setRespRandom('0);
    clearModel();
    repeat (2) @(posedge Clock);
    #1;
    checkOutput("reset busy", DW'(Busy), 0);
    checkOutput("reset done", DW'(Done), 0);
    checkOutput("reset ue", DW'(UpdateEnable), 0);
    checkOutput("reset sv", DW'(SpikeValid), 0);
    checkOutput("reset saddr", DW'(SpikeAddr), 0);
    checkOutput("reset addr", DW'(NeuronAddr), 0);
    checkOutput("reset vmem", Vmem, 0);
`ifdef NEURON_SPIKE_COUNT_EN
    checkOutput("reset cnt", DW'(SpikeCount), 0);
`endif
    Reset = 1'b0;
    @(posedge Clock); #1;

    $display("[TB] plain sweep, no spikes");
    setRespRandom('0);
    applyStimulus("plain", 1'b0, 0, '0, -1, -1);

    $display("[TB] initial load of -65.0 at neuron 3");
    initWrite(3, 64'hFFFF_FFBF_0000_0000);
    setRespRandom(16'($urandom));
    applyStimulus("init3", 1'b0, 0, '0, -1, -1);

    $display("[TB] ramp responses, spikes at 5 and 15");
    setRespRamp(16'h8020);
    applyStimulus("ramp", 1'b0, 0, '0, -1, -1);

    $display("[TB] Start and InitWrEn while busy");
    setRespRandom(16'($urandom));
    applyStimulus("busy", 1'b0, 0, '0, 10, 12);

    $display("[TB] reset mid-sweep");
    setRespRandom('1);
    resetMidSweep();
    setRespRandom(16'($urandom));
    applyStimulus("postrst", 1'b0, 0, '0, -1, -1);

    $display("[TB] load and Start in the same cycle");
    setRespRandom(16'($urandom));
    applyStimulus("initstart", 1'b1, 0, 64'd10, -1, -1);

    $display("[TB] random sweeps");
    for (int s = 0; s < 3; s++) begin
      setRespRandom(16'($urandom));
      applyStimulus($sformatf("rand%0d", s), 1'b1, $urandom_range(0, N - 1),
                    {$urandom, $urandom}, $urandom_range(1, 2 * N), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
